// File: rtl/kernel_entry_ctrl.sv
// Interrupt entry/exit sequencer: latches pending requests, stalls the core while
// state is saved, vectors to the handler and restores the interrupted context on eret.
module kernel_entry_ctrl #(
  parameter int          NUM_IRQ     = 4,
  parameter logic [15:0] VECTOR_BASE = 16'h0100,
  parameter int          SAVE_CYCLES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_IRQ-1:0]         irq_req,
  input  logic                       irq_enable,
  input  logic                       instr_boundary,
  input  logic                       eret,
  input  logic [15:0]                pc,
  output logic                       stall,
  output logic                       pc_load,
  output logic [15:0]                pc_target,
  output logic                       in_kernel,
  output logic                       restore,
  output logic [NUM_IRQ-1:0]         irq_ack,
  output logic [$clog2(NUM_IRQ)-1:0] irq_cause
);

  localparam int CW    = $clog2(NUM_IRQ);
  localparam int CNT_W = (SAVE_CYCLES > 1) ? $clog2(SAVE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAVE_CYCLES - 1);

  typedef enum logic [2:0] {USER, SAVE, VECTOR, KERNEL, RESTORE} state_t;

  state_t             state_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] ack;
  logic [15:0]        epc_q;
  logic [CW-1:0]      cause_q;
  logic [CW-1:0]      sel;
  logic [CNT_W-1:0]   cnt_q;
  logic               take_irq;

  // Lowest index wins, so scan from the top down and let lower hits overwrite.
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = CW'(i);
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == VECTOR) ack[cause_q] = 1'b1;
  end

  // A new request in the ack cycle keeps its bit set.
  assign pending_d = (pending_q & ~ack) | irq_req;
  assign take_irq  = instr_boundary & irq_enable & (|pending_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= USER;
      pending_q <= '0;
      epc_q     <= '0;
      cause_q   <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        USER: begin
          if (take_irq) begin
            state_q <= SAVE;
            epc_q   <= pc;
            cause_q <= sel;
            cnt_q   <= '0;
          end
        end
        SAVE: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= VECTOR;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        VECTOR:  state_q <= KERNEL;
        KERNEL:  if (eret) state_q <= RESTORE;
        RESTORE: state_q <= USER;
        default: state_q <= USER;
      endcase
    end
  end

  assign stall     = (state_q == SAVE) || (state_q == VECTOR) || (state_q == RESTORE);
  assign pc_load   = (state_q == VECTOR) || (state_q == RESTORE);
  assign in_kernel = (state_q == VECTOR) || (state_q == KERNEL) || (state_q == RESTORE);
  assign restore   = (state_q == RESTORE);
  assign irq_ack   = ack;
  assign irq_cause = (state_q == USER) ? '0 : cause_q;

  always_comb begin
    case (state_q)
      VECTOR:  pc_target = VECTOR_BASE + (16'(cause_q) << 2);
      RESTORE: pc_target = epc_q;
      default: pc_target = '0;
    endcase
  end

endmodule

// File: doc/kernel_entry_ctrl.md
KERNEL_ENTRY_CTRL -- requirements
Module: kernel_entry_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; the ports SHALL be named clock and reset.
REQ-002 The block SHALL have these parameters:
- NUM_IRQ, default 4, number of interrupt lines (2..8).
- VECTOR_BASE, default 16'h0100, first handler address.
- SAVE_CYCLES, default 2, stall cycles in SAVE (>=1).
REQ-003 The block SHALL have these ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- irq_req  in  NUM_IRQ  interrupt request; any cycle high sets the pending bit.
- irq_enable  in  1  global interrupt enable.
- instr_boundary  in  1  core is between instructions.
- eret  in  1  kernel-return instruction executing (pulse).
- pc  in  16  current program counter.
- stall  out  1  freezes register and ALU writes and the PC.
- pc_load  out  1  PC takes pc_target this cycle.
- pc_target  out  16  vector or return address.
- in_kernel  out  1  kernel mode; drives the backup register copy.
- restore  out  1  copy backup registers into the live registers.
- irq_ack  out  NUM_IRQ  one-hot acknowledge of the serviced line.
- irq_cause  out  clog2(NUM_IRQ)  index of the line being serviced.

Function
REQ-004 The FSM SHALL have the states USER, SAVE, VECTOR, KERNEL and RESTORE. All outputs SHALL be Moore outputs decoded from registered state.
REQ-005 pending[i] SHALL be set on the edge after irq_req[i]=1 and cleared only by its ack. If set and ack fall in the same cycle, set wins.
REQ-006 USER to SAVE SHALL occur when instr_boundary=1, irq_enable=1 and pending!=0. On that edge the block SHALL latch epc<=pc and cause<=lowest set pending index (index 0 has highest priority).
REQ-007 In USER, the outputs stall, pc_load, in_kernel, restore and irq_ack SHALL all be 0. Pending bits SHALL be retained while irq_enable=0.
REQ-008 SAVE SHALL last exactly SAVE_CYCLES cycles, counted by an internal counter, with stall=1 and in_kernel=0, and SHALL then go to VECTOR.
REQ-009 VECTOR SHALL last one cycle with stall=1, pc_load=1, in_kernel=1, irq_ack[cause]=1 and pc_target=VECTOR_BASE+cause*4 (mod 2^16). pending[cause] SHALL clear on the exit edge, and the next state SHALL be KERNEL.
REQ-010 In KERNEL, in_kernel SHALL be 1 and stall SHALL be 0. New requests SHALL only accumulate in pending; there is no nesting. eret=1 SHALL go to RESTORE.
REQ-011 RESTORE SHALL last one cycle with stall=1, pc_load=1, restore=1, in_kernel=1 and pc_target=epc, and SHALL then go to USER.
REQ-012 eret SHALL be ignored in USER, SAVE, VECTOR and RESTORE.
REQ-013 irq_cause SHALL show the latched cause in SAVE through RESTORE and 0 in USER. pc_target SHALL be 0 whenever pc_load=0.
REQ-014 Interrupt-entry latency SHALL be fixed: a request at cycle t, with boundary and enable high at t+1, SHALL produce SAVE at t+2 and VECTOR at t+2+SAVE_CYCLES.

Reset
REQ-015 reset=1 SHALL force, on the next edge and from any state, all of the following:
- state=USER.
- pending=0, epc=0, cause=0, counter=0.
- all outputs 0.
REQ-016 While reset=1, irq_req SHALL NOT set pending. A reset in mid-service SHALL drop the in-flight interrupt without an ack.

Verification
REQ-017 The bench SHALL cover the following directed scenarios (defaults: NUM_IRQ=4, VECTOR_BASE=0x0100, SAVE_CYCLES=2):
- Reset: hold reset 2 cycles with irq_req=4'hF, release with irq_req=0 and boundary=enable=1. Required: all outputs stay 0, no SAVE ever.
- Single interrupt: irq_req=4'b0100 pulse at t=0, pc=0x0234. Required: stall=1 at t=2..4; at t=4 pc_target=0x0108, irq_ack=4'b0100, in_kernel=1; eret at t=7 gives RESTORE at t=8 with pc_target=0x0234 and restore=1; USER at t=9.
- Priority: irq_req=4'b1010 in one cycle. Required: vector 0x0104 first with bit 3 still pending; after RESTORE and the next boundary, vector 0x010C.
- Gating: pending=4'b0001 with enable=0 for 5 cycles gives USER and stall=0; enable=1 with boundary=0 gives no entry; boundary=1 gives SAVE on the next edge.
- Ignored events: eret during SAVE gives no effect; irq_req=4'b0010 during KERNEL gives no ack until after RESTORE, then vector 0x0104.
- Reset mid-service: reset in KERNEL. Required: next cycle USER, in_kernel=0, pending=0, no restore pulse.
